// File: rtl/ascon_patch_fetch.sv
// Patch fetch front-end for the ASCON decryption stage: a small fully-associative
// patch cache, refilled beat by beat from a narrow patch memory on a miss.
module ascon_patch_fetch #(
  parameter int PATCH_WIDTH          = 320,
  parameter int PATCH_MEM_ADDR_WIDTH = 16,
  parameter int MEM_WIDTH            = 64,
  parameter int CACHE_ENTRIES        = 2,
  localparam int BEATS   = PATCH_WIDTH / MEM_WIDTH,
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int IDX_W   = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1,
  localparam int MADDR_W = PATCH_MEM_ADDR_WIDTH + CNT_W
) (
  input  logic                            clk_core_slow_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            req_valid_i,
  input  logic [PATCH_MEM_ADDR_WIDTH-1:0] req_addr_i,
  output logic                            req_ready_o,
  output logic                            patch_valid_o,
  output logic [PATCH_WIDTH-1:0]          patch_o,
  output logic                            mem_req_o,
  output logic [MADDR_W-1:0]              mem_addr_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [MEM_WIDTH-1:0]            mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

  state_t                          state_q, state_d;
  logic [PATCH_MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [PATCH_WIDTH-1:0]          line_q;
  logic [CACHE_ENTRIES-1:0]        valid_q;
  logic [PATCH_MEM_ADDR_WIDTH-1:0] tag_q  [CACHE_ENTRIES];
  logic [PATCH_WIDTH-1:0]          data_q [CACHE_ENTRIES];
  logic [IDX_W-1:0]                rr_q;
  logic                            flushed_q;
  logic [PATCH_WIDTH-1:0]          patch_q;
  logic                            patch_valid_q;

  logic [CACHE_ENTRIES-1:0]        tag_match;
  logic [IDX_W-1:0]                hit_idx;
  logic [IDX_W-1:0]                rr_next;
  logic                            accept;
  logic                            hit;
  logic                            beat_done;
  logic                            last_beat;
  logic                            install;

  genvar gi;
  generate
    for (gi = 0; gi < CACHE_ENTRIES; gi++) begin : g_lookup
      assign tag_match[gi] = valid_q[gi] && (tag_q[gi] == req_addr_i);
    end
  endgenerate

  // Lowest matching index wins should two entries ever share a tag.
  always_comb begin
    hit_idx = '0;
    for (int i = CACHE_ENTRIES - 1; i >= 0; i--) begin
      if (tag_match[i]) hit_idx = IDX_W'(i);
    end
  end

  assign accept    = req_valid_i && (state_q == S_IDLE);
  assign hit       = accept && (|tag_match) && !flush_i;
  assign beat_done = (state_q == S_WAIT) && mem_rvalid_i;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  // A flush seen anywhere during the fetch (or in the fill cycle) vetoes the install.
  assign install   = (state_q == S_FILL) && !flushed_q && !flush_i;
  assign rr_next   = (rr_q == IDX_W'(CACHE_ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);

  assign patch_o       = patch_q;
  assign patch_valid_o = patch_valid_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (accept && !hit) begin
          addr_d  = req_addr_i;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q, cnt_q};
        if (mem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (last_beat) begin
            state_d = S_FILL;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_core_slow_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      valid_q       <= '0;
      rr_q          <= '0;
      flushed_q     <= 1'b0;
      patch_q       <= '0;
      patch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      patch_valid_q <= 1'b0;
      if (hit) begin
        patch_q       <= data_q[hit_idx];
        patch_valid_q <= 1'b1;
      end else if (state_q == S_FILL) begin
        patch_q       <= line_q;
        patch_valid_q <= 1'b1;
      end
      flushed_q <= accept ? 1'b0 : (flushed_q | flush_i);
      if (flush_i) begin
        valid_q <= '0;
      end else if (install) begin
        valid_q[rr_q] <= 1'b1;
        rr_q          <= rr_next;
      end
    end
  end

  // Line assembly and cache payload storage carry no reset; validity is tracked above.
  always_ff @(posedge clk_core_slow_i) begin
    if (!rst_i) begin
      if (beat_done) begin
        for (int b = 0; b < BEATS; b++) begin
          if (cnt_q == CNT_W'(b)) line_q[b*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata_i;
        end
      end
      if (install) begin
        tag_q[rr_q]  <= addr_q;
        data_q[rr_q] <= line_q;
      end
    end
  end

endmodule

// File: tb/tb_ascon_patch_fetch.sv
// Bench for ascon_patch_fetch: directed table, reset-abort sequence, and randomized
// requests checked against a tag-list cache model with a latency formula.
module tb_ascon_patch_fetch;
  localparam int PW    = 320;
  localparam int AW    = 16;
  localparam int MW    = 64;
  localparam int CE    = 2;
  localparam int BEATS = PW / MW;
  localparam int MAW   = AW + 3;
  localparam int LIMIT = 400;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           flush_i = 1'b0;
  logic           req_valid_i = 1'b0;
  logic [AW-1:0]  req_addr_i = '0;
  logic           req_ready_o;
  logic           patch_valid_o;
  logic [PW-1:0]  patch_o;
  logic           mem_req_o;
  logic [MAW-1:0] mem_addr_o;
  logic           mem_gnt_i = 1'b0;
  logic           mem_rvalid_i = 1'b0;
  logic [MW-1:0]  mem_rdata_i = '0;

  int n_vec = 0;
  int n_err = 0;
  int g_dly = 0;
  int r_dly = 0;
  logic [MAW-1:0] addr_log[$];

  bit          mv[CE];
  logic [15:0] mt[CE];
  int          rr;

  always #5 clk = ~clk;

  ascon_patch_fetch dut (
    .clk_core_slow_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o),
    .patch_valid_o(patch_valid_o),
    .patch_o(patch_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mem_word(input logic [MAW-1:0] ma);
    int beat;
    logic [7:0] pat;
    beat = int'(ma[2:0]);
    pat  = 8'((beat + 1) * 17);
    return {ma[MAW-1:3], 48'h0} ^ {8{pat}};
  endfunction

  function automatic logic [PW-1:0] exp_patch(input logic [15:0] a);
    logic [PW-1:0] p;
    for (int b = 0; b < BEATS; b++) p[b*MW +: MW] = mem_word({a, 3'(b)});
    return p;
  endfunction

  // Memory: gnt after g_dly extra cycles, rdata after r_dly extra cycles past the grant.
  initial begin
    forever begin
      if (mem_req_o === 1'b1 && rst_i !== 1'b1) begin
        logic [MAW-1:0] a;
        a = mem_addr_o;
        addr_log.push_back(a);
        for (int k = 0; k < g_dly; k++) begin
          @(negedge clk);
          chk("mem_addr_stable", mem_addr_o, a);
          chk("mem_req_held", mem_req_o, 1);
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        repeat (r_dly) @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(a);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = MW'($urandom);
      end else begin
        @(negedge clk);
      end
    end
  end

  function automatic bit model_hit(input logic [15:0] a, input bit fl_acc);
    if (fl_acc) return 1'b0;
    for (int i = 0; i < CE; i++) if (mv[i] && mt[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input logic [15:0] a, input bit fl_acc, input bit hit, input bit fl_mid);
    if (fl_acc || fl_mid) for (int i = 0; i < CE; i++) mv[i] = 1'b0;
    if (!hit && !fl_mid) begin
      mt[rr] = a;
      mv[rr] = 1'b1;
      rr = (rr + 1) % CE;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CE; i++) mv[i] = 1'b0;
    rr = 0;
  endtask

  task automatic run_txn(input logic [15:0] a, input bit fl_acc, input int fl_at,
                         input int g, input int r, input bit exp_hit, input int exp_lat);
    int lat;
    logic [PW-1:0] ep;
    g_dly = g;
    r_dly = r;
    addr_log.delete();
    ep = exp_patch(a);
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    flush_i     = fl_acc;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i  = AW'($urandom);
    flush_i     = 1'b0;
    lat = 1;
    while (patch_valid_o !== 1'b1 && lat <= LIMIT) begin
      flush_i = (lat == fl_at);
      @(negedge clk);
      lat++;
    end
    flush_i = 1'b0;
    chk("latency", lat, exp_lat);
    chk("patch", patch_o, ep);
    chk("mem_beats", addr_log.size(), exp_hit ? 0 : BEATS);
    for (int b = 0; b < addr_log.size() && b < BEATS; b++) chk("mem_addr", addr_log[b], {a, 3'(b)});
    @(negedge clk);
    chk("pulse_end", patch_valid_o, 0);
    chk("patch_hold", patch_o, ep);
    $display("txn addr=%04h flush_acc=%0d flush_at=%0d lat=%0d hit=%0d", a, fl_acc, fl_at, lat, exp_hit);
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          fl_acc;
    int          fl_at;
    int          g;
    int          r;
    bit          exp_hit;
    int          exp_lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h0010, 1'b0, 0, 0, 0, 1'b0, 12};
    tbl[1]  = '{16'h0010, 1'b0, 0, 0, 0, 1'b1, 1};
    tbl[2]  = '{16'h0001, 1'b0, 0, 0, 0, 1'b0, 12};
    tbl[3]  = '{16'h0002, 1'b0, 0, 0, 0, 1'b0, 12};
    tbl[4]  = '{16'h0003, 1'b0, 0, 0, 0, 1'b0, 12};
    tbl[5]  = '{16'h0001, 1'b0, 0, 0, 0, 1'b0, 12};
    tbl[6]  = '{16'h0003, 1'b0, 0, 0, 0, 1'b1, 1};
    tbl[7]  = '{16'h0040, 1'b0, 0, 2, 1, 1'b0, 27};
    tbl[8]  = '{16'h0020, 1'b0, 2, 0, 0, 1'b0, 12};
    tbl[9]  = '{16'h0020, 1'b0, 0, 0, 0, 1'b0, 12};
    tbl[10] = '{16'h0020, 1'b1, 0, 0, 0, 1'b0, 12};
    tbl[11] = '{16'h0020, 1'b0, 0, 0, 0, 1'b1, 1};
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_patch_valid", patch_valid_o, 0);
    chk("rst_patch", patch_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      bit h;
      h = model_hit(tbl[i].addr, tbl[i].fl_acc);
      run_txn(tbl[i].addr, tbl[i].fl_acc, tbl[i].fl_at, tbl[i].g, tbl[i].r,
              tbl[i].exp_hit, tbl[i].exp_lat);
      model_update(tbl[i].addr, tbl[i].fl_acc, h, (tbl[i].fl_at != 0) && !h);
    end

    // Reset in the middle of a fetch, at beat 2.
    begin
      bit found;
      g_dly = 0;
      r_dly = 0;
      req_valid_i = 1'b1;
      req_addr_i  = 16'h0010;
      @(negedge clk);
      req_valid_i = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
        if (mem_req_o === 1'b1 && mem_addr_o === {16'h0010, 3'd2}) found = 1'b1;
        else @(negedge clk);
      end
      chk("rst_reach_beat2", found, 1);
      rst_i = 1'b1;
      @(negedge clk);
      chk("midrst_ready", req_ready_o, 1);
      chk("midrst_patch_valid", patch_valid_o, 0);
      chk("midrst_patch", patch_o, 0);
      chk("midrst_mem_req", mem_req_o, 0);
      chk("midrst_mem_addr", mem_addr_o, 0);
      rst_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("midrst_no_patch", patch_valid_o, 0);
      end
      model_reset();
      $display("txn reset at beat 2 of addr=0010");
      run_txn(16'h0010, 1'b0, 0, 0, 0, 1'b0, 12);
      model_update(16'h0010, 1'b0, 1'b0, 1'b0);
      run_txn(16'h0010, 1'b0, 0, 0, 0, 1'b1, 1);
      model_update(16'h0010, 1'b0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      bit fl_acc, h;
      int g, r, explat, fl_at, gap;
      a      = 16'($urandom_range(0, 4));
      fl_acc = ($urandom_range(0, 7) == 0);
      g      = $urandom_range(0, 2);
      r      = $urandom_range(0, 2);
      h      = model_hit(a, fl_acc);
      explat = h ? 1 : 2 + BEATS * (g + r + 2);
      fl_at  = (!h && $urandom_range(0, 5) == 0) ? $urandom_range(1, explat - 1) : 0;
      run_txn(a, fl_acc, fl_at, g, r, h, explat);
      model_update(a, fl_acc, h, fl_at != 0);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        flush_i = ($urandom_range(0, 9) == 0);
        if (flush_i) for (int e = 0; e < CE; e++) mv[e] = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
